// File: rtl/abacus_pkg.sv
// Shared types and constants for the ABACUS profiler measurement-window sequencer.
package abacus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    ARMED    = 3'd2,
    RUN      = 3'd3,
    SNAPSHOT = 3'd4
  } abacus_win_state_t;

  localparam int ABACUS_UNIT_INSTR = 0;
  localparam int ABACUS_UNIT_CACHE = 1;
  localparam int ABACUS_NUM_UNITS  = 2;
  localparam int ABACUS_CNT_W      = 32;
  localparam int ABACUS_WIN_CNT_W  = 16;

endpackage

// File: rtl/abacus_window_timer.sv
// Loadable down-counter that parks at zero and flags when it holds exactly one.
module abacus_window_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         term
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Load has priority; a zero count never decrements so zero means free-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign term  = (count_r == ONE);

endmodule

// File: rtl/abacus_window_ctrl.sv
// Measurement-window sequencer gating the ABACUS profiler units.
// Optional snapshot-ack timeout: define ABACUS_WINDOW_SNAP_TIMEOUT_EN.
module abacus_window_ctrl
  import abacus_pkg::*;
#(
  parameter int NUM_UNITS    = ABACUS_NUM_UNITS,
  parameter int CNT_W        = ABACUS_CNT_W,
  parameter int WIN_CNT_W    = ABACUS_WIN_CNT_W,
  parameter int SNAP_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic                 cfg_periodic,
  input  logic                 cfg_trigger_en,
  input  logic [CNT_W-1:0]     cfg_window_len,
  input  logic [NUM_UNITS-1:0] cfg_unit_mask,
  input  logic                 trigger,
  input  logic                 snapshot_ack,
  input  logic                 irq_clear,
  output logic [NUM_UNITS-1:0] unit_enable,
  output logic                 counter_clear,
  output logic                 snapshot_req,
  output logic                 window_done,
  output logic                 irq,
  output logic                 busy,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     cycles_remaining,
  output logic [WIN_CNT_W-1:0] windows_completed
`ifdef ABACUS_WINDOW_SNAP_TIMEOUT_EN
  ,
  output logic                 snap_timeout_err
`endif
);

  abacus_win_state_t state_r;
  abacus_win_state_t state_nx_s;

  logic                 win_term_s;
  logic                 snap_done_s;
  logic                 stop_pending_r;
  logic                 stop_eff_s;
  logic [NUM_UNITS-1:0] unit_enable_nx_s;
  logic                 counter_clear_nx_s;
  logic                 snapshot_req_nx_s;
  logic                 busy_nx_s;
  logic [NUM_UNITS-1:0] unit_enable_r;
  logic                 counter_clear_r;
  logic                 snapshot_req_r;
  logic                 busy_r;
  logic                 window_done_r;
  logic                 irq_r;
  logic [WIN_CNT_W-1:0] windows_completed_r;

  abacus_window_timer #(.W(CNT_W)) u_win_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_r == CLEAR),
    .load_val (cfg_window_len),
    .dec      (state_r == RUN),
    .count    (cycles_remaining),
    .term     (win_term_s)
  );

`ifdef ABACUS_WINDOW_SNAP_TIMEOUT_EN
  logic             snap_term_s;
  logic             snap_timeout_s;
  logic             snap_timeout_err_r;
  logic [CNT_W-1:0] unused_snap_count_s;

  // Reloaded outside SNAPSHOT so it always starts a fresh budget on entry.
  abacus_window_timer #(.W(CNT_W)) u_snap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_r != SNAPSHOT),
    .load_val (CNT_W'(SNAP_TIMEOUT)),
    .dec      (state_r == SNAPSHOT),
    .count    (unused_snap_count_s),
    .term     (snap_term_s)
  );

  assign snap_timeout_s = (state_r == SNAPSHOT) && snap_term_s && !snapshot_ack;
  assign snap_done_s    = (state_r == SNAPSHOT) && (snapshot_ack || snap_term_s);

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_timeout_err_r <= 1'b0;
    end else if (snap_timeout_s) begin
      snap_timeout_err_r <= 1'b1;
    end else if (irq_clear) begin
      snap_timeout_err_r <= 1'b0;
    end else begin
      snap_timeout_err_r <= snap_timeout_err_r;
    end
  end

  assign snap_timeout_err = snap_timeout_err_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (SNAP_TIMEOUT != 0);
  assign snap_done_s      = (state_r == SNAPSHOT) && snapshot_ack;
`endif

  // A stop arriving on the ack cycle still suppresses the periodic re-arm.
  assign stop_eff_s = stop_pending_r || cfg_stop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; stop always takes precedence over start and trigger.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_stop)       state_nx_s = IDLE;
        else if (cfg_start) state_nx_s = CLEAR;
        else                state_nx_s = IDLE;
      end
      CLEAR: begin
        if (cfg_stop)            state_nx_s = IDLE;
        else if (cfg_trigger_en) state_nx_s = ARMED;
        else                     state_nx_s = RUN;
      end
      ARMED: begin
        if (cfg_stop)     state_nx_s = IDLE;
        else if (trigger) state_nx_s = RUN;
        else              state_nx_s = ARMED;
      end
      RUN: begin
        if (cfg_stop || win_term_s) state_nx_s = SNAPSHOT;
        else                        state_nx_s = RUN;
      end
      SNAPSHOT: begin
        if (snap_done_s) state_nx_s = (cfg_periodic && !stop_eff_s) ? CLEAR : IDLE;
        else             state_nx_s = SNAPSHOT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    unit_enable_nx_s   = {NUM_UNITS{1'b0}};
    counter_clear_nx_s = 1'b0;
    snapshot_req_nx_s  = 1'b0;
    busy_nx_s          = 1'b1;
    case (state_nx_s)
      IDLE:     busy_nx_s          = 1'b0;
      CLEAR:    counter_clear_nx_s = 1'b1;
      ARMED:    busy_nx_s          = 1'b1;
      RUN:      unit_enable_nx_s   = cfg_unit_mask;
      SNAPSHOT: snapshot_req_nx_s  = 1'b1;
      default:  busy_nx_s          = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_enable_r   <= {NUM_UNITS{1'b0}};
      counter_clear_r <= 1'b0;
      snapshot_req_r  <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      unit_enable_r   <= unit_enable_nx_s;
      counter_clear_r <= counter_clear_nx_s;
      snapshot_req_r  <= snapshot_req_nx_s;
      busy_r          <= busy_nx_s;
    end
  end

  // Completion bookkeeping: done pulse, irq (set beats clear), window count, stop latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_done_r       <= 1'b0;
      irq_r               <= 1'b0;
      windows_completed_r <= {WIN_CNT_W{1'b0}};
      stop_pending_r      <= 1'b0;
    end else begin
      window_done_r <= snap_done_s;
      if (snap_done_s)    irq_r <= 1'b1;
      else if (irq_clear) irq_r <= 1'b0;
      else                irq_r <= irq_r;
      if (snap_done_s && (windows_completed_r != {WIN_CNT_W{1'b1}}))
        windows_completed_r <= windows_completed_r + {{(WIN_CNT_W-1){1'b0}}, 1'b1};
      else
        windows_completed_r <= windows_completed_r;
      if (snap_done_s)
        stop_pending_r <= 1'b0;
      else if (cfg_stop && ((state_r == RUN) || (state_r == SNAPSHOT)))
        stop_pending_r <= 1'b1;
      else
        stop_pending_r <= stop_pending_r;
    end
  end

  assign unit_enable       = unit_enable_r;
  assign counter_clear     = counter_clear_r;
  assign snapshot_req      = snapshot_req_r;
  assign busy              = busy_r;
  assign window_done       = window_done_r;
  assign irq               = irq_r;
  assign windows_completed = windows_completed_r;
  assign state_o           = state_r;

endmodule

// File: tb/tb_abacus_window_ctrl.sv
// Directed bench for abacus_window_ctrl: cycle table for a one-shot window plus corner sequences.
module tb_abacus_window_ctrl;
  import abacus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0, cfg_periodic = 1'b0;
  logic        cfg_trigger_en = 1'b0, trigger = 1'b0, snapshot_ack = 1'b0, irq_clear = 1'b0;
  logic [31:0] cfg_window_len = 32'd0;
  logic [1:0]  cfg_unit_mask = 2'b00;
  logic [1:0]  unit_enable;
  logic        counter_clear, snapshot_req, window_done, irq, busy;
  logic [2:0]  state_o;
  logic [31:0] cycles_remaining;
  logic [15:0] windows_completed;
`ifdef ABACUS_WINDOW_SNAP_TIMEOUT_EN
  logic        snap_timeout_err;
`endif

  always #5 clk = ~clk;

  abacus_window_ctrl #(.NUM_UNITS(2), .CNT_W(32), .WIN_CNT_W(16), .SNAP_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_periodic(cfg_periodic), .cfg_trigger_en(cfg_trigger_en),
    .cfg_window_len(cfg_window_len), .cfg_unit_mask(cfg_unit_mask),
    .trigger(trigger), .snapshot_ack(snapshot_ack), .irq_clear(irq_clear),
    .unit_enable(unit_enable), .counter_clear(counter_clear), .snapshot_req(snapshot_req),
    .window_done(window_done), .irq(irq), .busy(busy), .state_o(state_o),
    .cycles_remaining(cycles_remaining), .windows_completed(windows_completed)
`ifdef ABACUS_WINDOW_SNAP_TIMEOUT_EN
    , .snap_timeout_err(snap_timeout_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst, start, stop, ack, iclr;
    logic [2:0]  st;
    logic [1:0]  en;
    logic        cc, req, wd, irq;
    logic [31:0] rem;
    logic [15:0] wc;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic p, logic a, logic c, logic [2:0] st,
                              logic [1:0] en, logic cc, logic req, logic wd, logic iq,
                              logic [31:0] rem, logic [15:0] wc);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.ack = a; v.iclr = c;
    v.st = st; v.en = en; v.cc = cc; v.req = req; v.wd = wd; v.irq = iq;
    v.rem = rem; v.wc = wc;
    return v;
  endfunction

  vec_t vecs[15];
  logic [1:0] full_mask;

  initial begin
    full_mask = 2'b00;
    full_mask[ABACUS_UNIT_INSTR] = 1'b1;
    full_mask[ABACUS_UNIT_CACHE] = 1'b1;

    //                  rst   start stop  ack   iclr  st    en     cc    req   wd    irq   rem    wc
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 16'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 16'd0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 16'd0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 16'd0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'd0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 16'd1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 16'd1);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd1);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd1);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd1);

    // One-shot window of 5 cycles, table driven.
    cfg_window_len = 32'd5;
    cfg_unit_mask  = full_mask;
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; cfg_start = vecs[i].start; cfg_stop = vecs[i].stop;
      snapshot_ack = vecs[i].ack; irq_clear = vecs[i].iclr;
      step();
      chk($sformatf("v%0d state", i), state_o, vecs[i].st);
      chk($sformatf("v%0d unit_enable", i), unit_enable, vecs[i].en);
      chk($sformatf("v%0d counter_clear", i), counter_clear, vecs[i].cc);
      chk($sformatf("v%0d snapshot_req", i), snapshot_req, vecs[i].req);
      chk($sformatf("v%0d window_done", i), window_done, vecs[i].wd);
      chk($sformatf("v%0d irq", i), irq, vecs[i].irq);
      chk($sformatf("v%0d cycles_remaining", i), cycles_remaining, vecs[i].rem);
      chk($sformatf("v%0d windows_completed", i), windows_completed, vecs[i].wc);
      chk($sformatf("v%0d busy", i), busy, (vecs[i].st != 3'd0));
    end
    rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; snapshot_ack = 1'b0; irq_clear = 1'b0;

    // Periodic: three windows with immediate ack, stop during the third snapshot.
    begin
      int cc_n, wd_n, en_n;
      bit stopped;
      do_reset();
      cfg_periodic = 1'b1; cfg_window_len = 32'd4; snapshot_ack = 1'b1;
      cfg_start = 1'b1; step(); cfg_start = 1'b0;
      cc_n = int'(counter_clear); wd_n = 0; en_n = 0; stopped = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cfg_stop = (state_o == 3'd4) && (windows_completed == 16'd2) && !stopped;
        if (cfg_stop) stopped = 1'b1;
        step();
        cfg_stop = 1'b0;
        cc_n += int'(counter_clear);
        wd_n += int'(window_done);
        if (unit_enable != 2'b00) en_n++;
      end
      chk("periodic windows_completed", windows_completed, 16'd3);
      chk("periodic final state", state_o, 3'd0);
      chk("periodic clear pulses", cc_n, 3);
      chk("periodic done pulses", wd_n, 3);
      chk("periodic enabled cycles", en_n, 12);
      snapshot_ack = 1'b0; cfg_periodic = 1'b0;
    end

    // Trigger: enable held off while armed, then exactly 3 counting cycles.
    begin
      int en_n;
      do_reset();
      cfg_trigger_en = 1'b1; cfg_window_len = 32'd3;
      cfg_start = 1'b1; step(); cfg_start = 1'b0;
      chk("trig clear state", state_o, 3'd1);
      en_n = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (unit_enable != 2'b00) en_n++;
      end
      chk("trig armed state", state_o, 3'd2);
      chk("trig armed enable cycles", en_n, 0);
      trigger = 1'b1; step(); trigger = 1'b0;
      chk("trig run state", state_o, 3'd3);
      en_n = (unit_enable != 2'b00) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (unit_enable != 2'b00) en_n++;
      end
      chk("trig enabled cycles", en_n, 3);
      chk("trig snapshot state", state_o, 3'd4);
      snapshot_ack = 1'b1; step(); snapshot_ack = 1'b0;
      chk("trig windows_completed", windows_completed, 16'd1);
      cfg_trigger_en = 1'b0;
    end

`ifdef ABACUS_WINDOW_SNAP_TIMEOUT_EN
    // Snapshot timeout with no ack ever given.
    begin
      int reqc;
      bit seen;
      logic wd_at, err_at;
      do_reset();
      cfg_window_len = 32'd2;
      cfg_start = 1'b1; step(); cfg_start = 1'b0;
      reqc = 0; seen = 1'b0; wd_at = 1'b0; err_at = 1'b0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (snapshot_req) reqc++;
        else if (reqc > 0 && !seen) begin
          seen = 1'b1; wd_at = window_done; err_at = snap_timeout_err;
        end
      end
      chk("timeout req cycles", reqc, 8);
      chk("timeout window_done", wd_at, 1'b1);
      chk("timeout err", err_at, 1'b1);
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      chk("timeout irq cleared", irq, 1'b0);
      chk("timeout err cleared", snap_timeout_err, 1'b0);
    end
`endif

    // Free-run: window_len 0, stop after 100 enabled cycles.
    begin
      int en_n, rem_nz;
      do_reset();
      cfg_window_len = 32'd0; cfg_unit_mask = 2'b01;
      cfg_start = 1'b1; step(); cfg_start = 1'b0;
      en_n = 0; rem_nz = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (unit_enable == 2'b01) en_n++;
        if (cycles_remaining != 32'd0) rem_nz++;
      end
      chk("freerun enabled cycles", en_n, 100);
      chk("freerun remaining moved", rem_nz, 0);
      cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
      chk("freerun stop state", state_o, 3'd4);
      chk("freerun stop enable", unit_enable, 2'b00);
      chk("freerun snapshot_req", snapshot_req, 1'b1);
      snapshot_ack = 1'b1; step(); snapshot_ack = 1'b0;
      chk("freerun window_done", window_done, 1'b1);
      chk("freerun windows_completed", windows_completed, 16'd1);
      chk("freerun idle", state_o, 3'd0);
    end

    // Stop in ARMED beats a simultaneous trigger; no snapshot follows.
    cfg_trigger_en = 1'b1; cfg_unit_mask = full_mask; cfg_window_len = 32'd4;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    step();
    chk("armed state", state_o, 3'd2);
    cfg_stop = 1'b1; trigger = 1'b1; step(); cfg_stop = 1'b0; trigger = 1'b0;
    chk("armed stop state", state_o, 3'd0);
    chk("armed stop busy", busy, 1'b0);
    step();
    chk("armed stop no snapshot", snapshot_req, 1'b0);
    cfg_trigger_en = 1'b0;

    // Reset mid-RUN clears everything, including irq and the window count.
    cfg_window_len = 32'd20;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrun state", state_o, 3'd3);
    chk("midrun irq still set", irq, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst state", state_o, 3'd0);
    chk("rst unit_enable", unit_enable, 2'b00);
    chk("rst snapshot_req", snapshot_req, 1'b0);
    chk("rst counter_clear", counter_clear, 1'b0);
    chk("rst window_done", window_done, 1'b0);
    chk("rst irq", irq, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst cycles_remaining", cycles_remaining, 32'd0);
    chk("rst windows_completed", windows_completed, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
